// File: rtl/conv_stream_packetizer_if.sv
// conv_stream_packetizer_if
// Groups the stream handshakes and FIFO write ports of the packetizer.
//   pix_*    : pixel source (valid/ready) carrying raw IFmap pixels
//   filt_*   : filter word source (valid/ready)
//   IF_*     : IF FIFO write port, 18-bit tagged words {start, end, data}
//   filter_* : filter FIFO write port
// master = packetizer side, slave = sources/FIFOs side.
interface conv_stream_packetizer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FILT_WIDTH = 16
) ();
  logic                  pix_valid;
  logic [DATA_WIDTH-1:0] pix_data;
  logic                  pix_ready;
  logic                  filt_valid;
  logic [FILT_WIDTH-1:0] filt_data;
  logic                  filt_ready;
  logic                  IF_full;
  logic                  IF_wen;
  logic [DATA_WIDTH+1:0] IF_din;
  logic                  filter_full;
  logic                  filter_wen;
  logic [FILT_WIDTH-1:0] filter_din;

  modport master (
    input  pix_valid, pix_data, filt_valid, filt_data, IF_full, filter_full,
    output pix_ready, filt_ready, IF_wen, IF_din, filter_wen, filter_din
  );

  modport slave (
    output pix_valid, pix_data, filt_valid, filt_data, IF_full, filter_full,
    input  pix_ready, filt_ready, IF_wen, IF_din, filter_wen, filter_din
  );
endinterface

// File: rtl/conv_stream_packetizer.sv
// conv_stream_packetizer
// Drains one IFmap row and one filter word stream into the convolution
// core's IF and filter FIFOs, tagging the row words with start/end flags.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                begin a transfer (sampled in IDLE only)
//   row_len, filt_words  transfer lengths, latched on accepted start
//   bus (master)         pixel/filter sources and FIFO write ports
//   busy                 high in RUN and DONE
//   done                 one-cycle pulse after both streams are delivered
//   err_len              one-cycle pulse when start arrives with row_len==0
//
// state | meaning
// IDLE  | waiting for start
// RUN   | moving pixels and filter words until both counters reach 0
// DONE  | one cycle, done pulsed
module conv_stream_packetizer #(
  parameter int DATA_WIDTH = 16,
  parameter int FILT_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] row_len,
  input  logic [LEN_WIDTH-1:0] filt_words,
  conv_stream_packetizer_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err_len
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic [LEN_WIDTH-1:0] pix_rem;
  logic [LEN_WIDTH-1:0] filt_rem;
  logic [LEN_WIDTH-1:0] pix_idx;
  logic                 pix_hs;
  logic                 filt_hs;

  assign bus.pix_ready  = (state == RUN) && (pix_rem != '0) && !bus.IF_full;
  assign bus.filt_ready = (state == RUN) && (filt_rem != '0) && !bus.filter_full;

  assign pix_hs  = bus.pix_valid && bus.pix_ready;
  assign filt_hs = bus.filt_valid && bus.filt_ready;

  // FIFOs capture on the handshake edge; data buses are forced to 0 when idle.
  assign bus.IF_wen     = pix_hs;
  assign bus.IF_din     = pix_hs ? {(pix_idx == '0), (pix_rem == LEN_WIDTH'(1)), bus.pix_data} : '0;
  assign bus.filter_wen = filt_hs;
  assign bus.filter_din = filt_hs ? bus.filt_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pix_rem  <= '0;
      filt_rem <= '0;
      pix_idx  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_len  <= 1'b0;
    end else begin
      done    <= 1'b0;
      err_len <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (row_len != '0) begin
              state    <= RUN;
              busy     <= 1'b1;
              pix_rem  <= row_len;
              filt_rem <= filt_words;
              pix_idx  <= '0;
            end else begin
              err_len <= 1'b1;
            end
          end
        end
        RUN: begin
          // Handshakes only occur while the counter is non-zero, so no wrap.
          if (pix_hs) begin
            pix_rem <= pix_rem - LEN_WIDTH'(1);
            pix_idx <= pix_idx + LEN_WIDTH'(1);
          end
          if (filt_hs) begin
            filt_rem <= filt_rem - LEN_WIDTH'(1);
          end
          if ((pix_rem == '0) && (filt_rem == '0)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/conv_stream_packetizer.md
Name: conv_stream_packetizer

Overview:
- Transmit-side front end for the convolution core's input FIFOs. Drains one raw IFmap row and one filter word stream from valid/ready sources.
- Writes the row into the IF FIFO as 18-bit tagged words {start, end, data}. Writes filter words into the filter FIFO. Honours both FIFO full flags.
- Sits between the host/DMA side and the core's IF_wen/IF_din and filter_wen/filter_din inputs.
- Pulses done once both streams have been fully delivered.

Parameters:
- DATA_WIDTH, 16, IFmap pixel width; IF word is DATA_WIDTH+2 bits.
- FILT_WIDTH, 16, filter word width.
- LEN_WIDTH, 8, width of the row-length and filter-count registers.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a transfer; sampled only in IDLE.
- row_len  in  LEN_WIDTH  pixels in the row; sampled when start is accepted.
- filt_words  in  LEN_WIDTH  filter words to move; sampled when start is accepted.
- pix_valid  in  1  source has a pixel.
- pix_data  in  DATA_WIDTH  pixel value.
- pix_ready  out  1  packetizer accepts a pixel this cycle.
- filt_valid  in  1  source has a filter word.
- filt_data  in  FILT_WIDTH  filter value.
- filt_ready  out  1  packetizer accepts a filter word this cycle.
- IF_full  in  1  IF FIFO full.
- IF_wen  out  1  IF FIFO write enable.
- IF_din  out  DATA_WIDTH+2  {start_tag, end_tag, pixel}.
- filter_full  in  1  filter FIFO full.
- filter_wen  out  1  filter FIFO write enable.
- filter_din  out  FILT_WIDTH  filter word.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle completion pulse.
- err_len  out  1  one-cycle pulse when start is given with row_len==0.

Behaviour:
- FSM states: IDLE, RUN, DONE.
  - IDLE: start & row_len!=0 -> RUN. Latch pix_rem=row_len, filt_rem=filt_words, pix_idx=0.
  - IDLE: start & row_len==0 -> err_len=1 for one cycle; stay IDLE.
  - RUN: when pix_rem==0 and filt_rem==0 -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
  - start while in RUN or DONE is ignored.
- pix_ready = (state==RUN) & (pix_rem!=0) & ~IF_full. This is combinational.
- Pixel handshake = pix_valid & pix_ready.
- IF_wen = pixel handshake. Zero latency: the FIFO captures the word on the same edge as the handshake.
- IF_din is combinational: {pix_idx==0, pix_rem==1, pix_data}.
  - Tag 2'b10 marks the first pixel, 2'b00 a middle pixel, 2'b01 the last pixel.
  - A single-pixel row (row_len==1) carries tag 2'b11.
- On each pixel handshake: pix_rem decrements and pix_idx increments.
- filt_ready = (state==RUN) & (filt_rem!=0) & ~filter_full.
- filter_wen = filt_valid & filt_ready; filter_din = filt_data.
- On each filter handshake: filt_rem decrements.
- filt_words==0 means the filter channel is complete at entry; only pixels are moved.
- The two channels are independent. Simultaneous handshakes on both in one cycle are allowed; each decrements its own counter.
- While a FIFO is full, the matching ready stays low and its wen stays 0. Source data is held by the valid/ready rule; nothing is dropped or duplicated.
- Counters never wrap. No decrement is applied when the counter is 0.
- Reset values: state=IDLE, pix_rem=0, filt_rem=0, pix_idx=0. All outputs are 0: pix_ready, filt_ready, IF_wen, IF_din, filter_wen, filter_din, busy, done, err_len.
  - IF_din and filter_din are 0 whenever their wen is 0.
- Reset asserted mid-RUN: return to IDLE on the next edge and clear all counters. No partial-row completion; done is not pulsed.
- busy is registered from state: high in RUN and DONE.
- Minimum transfer time = max(row_len, filt_words) cycles in RUN, plus 1 cycle in DONE.

Test Plan:
- Nominal row: row_len=10, filt_words=6, IF and filter FIFOs never full. Pixels 0,0,-1,2,-1,-2,2,0,1,1 and filters -130,-53,177,-120,-121,25, valid held high.
  -> IF_din sequence 0x20000, 0x00000, 0x0FFFF, 0x00002, 0x0FFFF, 0x0FFFE, 0x00002, 0x00000, 0x00001, 0x10001.
  -> filter_din sequence 0xFF7E, 0xFFCB, 0x00B1, 0xFF88, 0xFF87, 0x0019.
  -> done pulses 11 cycles after start is accepted.
- Backpressure: same row with IF_full high for cycles 3-5 of RUN.
  -> pix_ready=0 and IF_wen=0 in those cycles.
  -> The pixel held on pix_data (value 2) is written once, after IF_full drops.
  -> done is delayed by 3 cycles.
- Single pixel: row_len=1, pixel 7, filt_words=0.
  -> One write with IF_din=0x30007.
  -> done exactly 2 cycles after start is accepted.
- Zero length: start with row_len=0.
  -> err_len=1 for one cycle; busy stays 0; no writes on either FIFO.
- Reset mid-operation: rst asserted after 4 pixels of a 10-pixel row.
  -> Next cycle busy=0 and IF_wen=0.
  -> A new start with row_len=3 emits tags 10, 00, 01.
- Start during RUN: a second start pulse with row_len=5 mid-row.
  -> Ignored; the original row completes with its original length.
